serial_tx_sched: RTL and testbench

- Scheduler/arbiter that shares one 16-bit serial shift-out datapath between two word requesters (A, B).
- The datapath loads its parallel input on a clock edge where its load strobe is high, then rotates left each clock. The MSB is the serial output.
- This block picks a requester by round-robin and latches its word. It pulses the load strobe and frames the following WIDTH bit periods.
- It then enforces a programmable idle gap before the next word.

---
 rtl/serial_tx_sched_if.sv | 46 ++++
 rtl/serial_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_serial_tx_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_sched_if.sv
// Handshake and shifter-facing bundle for serial_tx_sched. The master modport is the scheduler.
// Build with PARITY_EN defined to add the parity output and widen bit_idx.
interface serial_tx_sched_if #(
    parameter int WIDTH = 16
);
`ifdef PARITY_EN
    localparam int IDXW = $clog2(WIDTH + 1);
`else
    localparam int IDXW = $clog2(WIDTH);
`endif

    logic             req_a;
    logic [WIDTH-1:0] din_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] din_b;
    logic             ack_b;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             frame;
    logic [IDXW-1:0]  bit_idx;
    logic             owner;
    logic             done;
    logic             busy;
`ifdef PARITY_EN
    logic             parity;

    modport master (
        input  req_a, din_a, req_b, din_b,
        output ack_a, ack_b, start, dout, frame, bit_idx, owner, done, busy, parity
    );
    modport slave (
        output req_a, din_a, req_b, din_b,
        input  ack_a, ack_b, start, dout, frame, bit_idx, owner, done, busy, parity
    );
`else
    modport master (
        input  req_a, din_a, req_b, din_b,
        output ack_a, ack_b, start, dout, frame, bit_idx, owner, done, busy
    );
    modport slave (
        output req_a, din_a, req_b, din_b,
        input  ack_a, ack_b, start, dout, frame, bit_idx, owner, done, busy
    );
`endif
endinterface

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler sharing one serial shifter between requesters A and B (optional PARITY_EN adds a parity bit period).
// Latency: ack/start one cycle after the grant edge, first serial bit two cycles after it; all outputs registered.
// Backpressure: req is a held level, ignored outside IDLE; a word is only taken when the block is idle.
module serial_tx_sched #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    serial_tx_sched_if.master   bus
);
`ifdef PARITY_EN
    localparam int IDXW = $clog2(WIDTH + 1);
`else
    localparam int IDXW = $clog2(WIDTH);
`endif
    localparam int GAPW = $clog2(GAP_CYCLES + 2);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
`endif

    state_t            state, state_nxt;
    logic [GAPW-1:0]   gap_cnt, gap_nxt;
    logic [IDXW-1:0]   bit_idx_q, idx_nxt;
    logic [WIDTH-1:0]  dout_q, dout_nxt;
    logic              owner_q, owner_nxt;
    logic              ack_a_q, ack_a_nxt;
    logic              ack_b_q, ack_b_nxt;
    logic              start_q, start_nxt;
    logic              frame_q, frame_nxt;
    logic              done_q, done_nxt;
    logic              busy_q, busy_nxt;
    logic              grant_b;
`ifdef PARITY_EN
    logic              parity_q, parity_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            bit_idx_q <= '0;
            dout_q    <= '0;
            owner_q   <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            start_q   <= 1'b0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            bit_idx_q <= idx_nxt;
            dout_q    <= dout_nxt;
            owner_q   <= owner_nxt;
            ack_a_q   <= ack_a_nxt;
            ack_b_q   <= ack_b_nxt;
            start_q   <= start_nxt;
            frame_q   <= frame_nxt;
            done_q    <= done_nxt;
            busy_q    <= busy_nxt;
`ifdef PARITY_EN
            parity_q  <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        idx_nxt    = '0;
        dout_nxt   = dout_q;
        owner_nxt  = owner_q;
        ack_a_nxt  = 1'b0;
        ack_b_nxt  = 1'b0;
        grant_b    = 1'b0;
`ifdef PARITY_EN
        parity_nxt = parity_q;
`endif
        case (state)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    // On contention the requester that did not own the last word wins.
                    grant_b   = (bus.req_a && bus.req_b) ? ~owner_q : bus.req_b;
                    state_nxt = LOAD;
                    owner_nxt = grant_b;
                    dout_nxt  = grant_b ? bus.din_b : bus.din_a;
                    ack_a_nxt = ~grant_b;
                    ack_b_nxt = grant_b;
`ifdef PARITY_EN
                    parity_nxt = grant_b ? ^bus.din_b : ^bus.din_a;
`endif
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_idx_q == IDX_LAST) begin
`ifdef PARITY_EN
                    state_nxt = PAR;
                    idx_nxt   = IDXW'(WIDTH);
`else
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                    gap_nxt   = '0;
`endif
                end else begin
                    idx_nxt = bit_idx_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            PAR: begin
                state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                gap_nxt   = '0;
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state so they line up with it once registered.
        start_nxt = (state_nxt == LOAD);
        busy_nxt  = (state_nxt != IDLE);
`ifdef PARITY_EN
        frame_nxt = (state_nxt == SHIFT) || (state_nxt == PAR);
        done_nxt  = (state_nxt == PAR);
`else
        frame_nxt = (state_nxt == SHIFT);
        done_nxt  = (state_nxt == SHIFT) && (idx_nxt == IDX_LAST);
`endif
    end

    assign bus.ack_a   = ack_a_q;
    assign bus.ack_b   = ack_b_q;
    assign bus.start   = start_q;
    assign bus.dout    = dout_q;
    assign bus.frame   = frame_q;
    assign bus.bit_idx = bit_idx_q;
    assign bus.owner   = owner_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
`ifdef PARITY_EN
    assign bus.parity  = parity_q;
`endif

endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: directed steps plus random requester traffic, two instances (GAP_CYCLES 2 and 0).
`timescale 1ns/1ps
module tb_serial_tx_sched;
    localparam int W = 16;
`ifdef PARITY_EN
    localparam int IW = $clog2(W + 1);
    localparam int PX = 1;
`else
    localparam int IW = $clog2(W);
    localparam int PX = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0;
    logic [W-1:0] din_a = '0, din_b = '0;

    always #5 clk = ~clk;

    serial_tx_sched_if #(.WIDTH(W)) bus ();
    serial_tx_sched_if #(.WIDTH(W)) bus0 ();

    assign bus.req_a  = req_a & ~sel;
    assign bus.req_b  = req_b & ~sel;
    assign bus.din_a  = din_a;
    assign bus.din_b  = din_b;
    assign bus0.req_a = req_a & sel;
    assign bus0.req_b = req_b & sel;
    assign bus0.din_a = din_a;
    assign bus0.din_b = din_b;

    serial_tx_sched #(.WIDTH(W), .GAP_CYCLES(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    serial_tx_sched #(.WIDTH(W), .GAP_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    logic m_ack_a, m_ack_b, m_start, m_frame, m_owner, m_done, m_busy;
    logic [W-1:0]  m_dout;
    logic [IW-1:0] m_idx;
    assign m_ack_a = sel ? bus0.ack_a   : bus.ack_a;
    assign m_ack_b = sel ? bus0.ack_b   : bus.ack_b;
    assign m_start = sel ? bus0.start   : bus.start;
    assign m_frame = sel ? bus0.frame   : bus.frame;
    assign m_owner = sel ? bus0.owner   : bus.owner;
    assign m_done  = sel ? bus0.done    : bus.done;
    assign m_busy  = sel ? bus0.busy    : bus.busy;
    assign m_dout  = sel ? bus0.dout    : bus.dout;
    assign m_idx   = sel ? bus0.bit_idx : bus.bit_idx;
`ifdef PARITY_EN
    logic m_par;
    assign m_par = sel ? bus0.parity : bus.parity;
`endif

    // Serial consumer: loads on start, rotates left otherwise, MSB is the line.
    logic [W-1:0] shreg;
    always @(posedge clk or posedge rst) begin
        if (rst) shreg <= '0;
        else if (m_start) shreg <= m_dout;
        else shreg <= {shreg[W-2:0], shreg[W-1]};
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit last_b = 1'b1;
    int unsigned ack_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_grant(input bit ra, input bit rb);
        return (ra && rb) ? ~last_b : rb;
    endfunction

    // One word as the specification describes it: LOAD, WIDTH bit periods, optional PAR, gap.
    task automatic run_word(input bit gb, input logic [W-1:0] word, input int gap,
                            input int exp_lat, input bit [1:0] drop, input int abort_at,
                            input bit disturb);
        int waited = 0;
        bit seen = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (m_ack_a || m_ack_b) seen = 1'b1;
            else chk("idle_busy", 32'(m_busy), 32'(0));
        end
        chk("ack_seen", 32'(seen), 32'(1));
        if (!seen) return;
        if (exp_lat > 0) chk("grant_lat", 32'(waited), 32'(exp_lat));
        ack_cyc = cyc;
        chk("ack_a", 32'(m_ack_a), 32'(!gb));
        chk("ack_b", 32'(m_ack_b), 32'(gb));
        chk("load_start", 32'(m_start), 32'(1));
        chk("load_busy", 32'(m_busy), 32'(1));
        chk("load_frame", 32'(m_frame), 32'(0));
        chk("load_dout", 32'(m_dout), 32'(word));
        chk("owner", 32'(m_owner), 32'(gb));
        last_b = gb;
        if (drop[0]) req_a = 1'b0;
        if (drop[1]) req_b = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("frame", 32'(m_frame), 32'(1));
            chk("shift_start", 32'(m_start), 32'(0));
            chk("shift_ack", 32'(m_ack_a | m_ack_b), 32'(0));
            chk("bit_idx", 32'(m_idx), 32'(k));
            chk("serial", 32'(shreg[W-1]), 32'(word[W-1-k]));
            chk("dout_hold", 32'(m_dout), 32'(word));
            chk("done", 32'(m_done), 32'((PX == 0) && (k == W - 1)));
            if (disturb && k == 3) begin req_a = 1'b1; din_a = ~word; end
            if (disturb && k == 9) req_a = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_frame", 32'(m_frame), 32'(0));
                chk("rst_start", 32'(m_start), 32'(0));
                chk("rst_busy", 32'(m_busy), 32'(0));
                chk("rst_dout", 32'(m_dout), 32'(0));
                chk("rst_owner", 32'(m_owner), 32'(1));
                last_b = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
`ifdef PARITY_EN
        @(negedge clk);
        chk("par_frame", 32'(m_frame), 32'(1));
        chk("par_idx", 32'(m_idx), 32'(W));
        chk("par_done", 32'(m_done), 32'(1));
        chk("parity", 32'(m_par), 32'(^word));
`endif
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_frame", 32'(m_frame), 32'(0));
            chk("gap_busy", 32'(m_busy), 32'(1));
            chk("gap_idx", 32'(m_idx), 32'(0));
            chk("gap_done", 32'(m_done), 32'(0));
            chk("gap_dout", 32'(m_dout), 32'(word));
        end
    endtask

    initial begin
        int unsigned t0;
        bit pa, pb, gb;
        logic [W-1:0] w;

        // Reset values while rst is held.
        @(negedge clk);
        chk("rst_ack_a", 32'(m_ack_a), 32'(0));
        chk("rst_ack_b", 32'(m_ack_b), 32'(0));
        chk("rst_start", 32'(m_start), 32'(0));
        chk("rst_frame", 32'(m_frame), 32'(0));
        chk("rst_done", 32'(m_done), 32'(0));
        chk("rst_busy", 32'(m_busy), 32'(0));
        chk("rst_dout", 32'(m_dout), 32'(0));
        chk("rst_idx", 32'(m_idx), 32'(0));
        chk("rst_owner", 32'(m_owner), 32'(1));
        rst = 1'b0;
        last_b = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(m_busy), 32'(0));

        // Single word from A.
        req_a = 1'b1; din_a = 16'hA5C3;
        run_word(1'b0, 16'hA5C3, 2, 1, 2'b01, -1, 1'b0);

        // Both held from reset: A, B, A, B at a fixed period.
        rst = 1'b1;
        req_a = 1'b1; req_b = 1'b1; din_a = 16'h0001; din_b = 16'h8000;
        @(negedge clk);
        rst = 1'b0; last_b = 1'b1;
        run_word(model_grant(1, 1), 16'h0001, 2, 1, 2'b00, -1, 1'b0);
        t0 = ack_cyc;
        run_word(model_grant(1, 1), 16'h8000, 2, 2, 2'b00, -1, 1'b0);
        chk("period_1", ack_cyc - t0, 32'(2 + W + 2 + PX)); t0 = ack_cyc;
        run_word(model_grant(1, 1), 16'h0001, 2, 2, 2'b00, -1, 1'b0);
        chk("period_2", ack_cyc - t0, 32'(2 + W + 2 + PX)); t0 = ack_cyc;
        run_word(model_grant(1, 1), 16'h8000, 2, 2, 2'b11, -1, 1'b0);
        chk("period_3", ack_cyc - t0, 32'(2 + W + 2 + PX));

        // req/din disturbed mid-frame must not affect the word in flight.
        req_a = 1'b1; din_a = 16'h00FF;
        run_word(model_grant(1, 0), 16'h00FF, 2, 2, 2'b01, -1, 1'b1);

        // Reset at bit 7 discards the word; no ack afterwards without a new request.
        req_a = 1'b1; din_a = 16'h1234;
        run_word(model_grant(1, 0), 16'h1234, 2, 2, 2'b01, 7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_ack", 32'(m_ack_a | m_ack_b), 32'(0));
            chk("post_rst_busy", 32'(m_busy), 32'(0));
        end

        // Odd-parity-count word.
        req_a = 1'b1; din_a = 16'h0007;
        run_word(model_grant(1, 0), 16'h0007, 2, 1, 2'b01, -1, 1'b0);

        // Random traffic: pending requests stay up until acked.
        pa = 1'b0; pb = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (!pa && $urandom_range(0, 1) == 1) begin pa = 1'b1; din_a = W'($urandom); end
            if (!pb && $urandom_range(0, 1) == 1) begin pb = 1'b1; din_b = W'($urandom); end
            if (!pa && !pb) begin pa = 1'b1; din_a = W'($urandom); end
            req_a = pa; req_b = pb;
            gb = model_grant(pa, pb);
            w = gb ? din_b : din_a;
            run_word(gb, w, 2, 2, gb ? 2'b10 : 2'b01, -1, 1'b0);
            if (gb) pb = 1'b0; else pa = 1'b0;
        end

        // Zero-gap instance: next grant right after the last bit.
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b1; sel = 1'b1;
        @(negedge clk);
        rst = 1'b0; last_b = 1'b1;
        req_b = 1'b1; din_b = 16'hFFFF;
        run_word(model_grant(0, 1), 16'hFFFF, 0, 1, 2'b00, -1, 1'b0);
        t0 = ack_cyc;
        run_word(model_grant(0, 1), 16'hFFFF, 0, 2, 2'b10, -1, 1'b0);
        chk("period_gap0", ack_cyc - t0, 32'(2 + W + PX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
